// File: rtl/regfile_mp.sv
// regfile_mp: 2-read / 2-write integer register file with write-first bypass,
// optional hardwired x0 and a clear sequencer. Define REGFILE_TRACE_EN for a simulation write trace.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear_req,
  output logic            ready,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   clr_ptr;
  logic [AW-1:0]   clr_ptr_nxt;
  logic [XLEN-1:0] regs [NREGS];
  logic            run;
  logic            wr0_ok;
  logic            wr1_ok;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 1'b0) && (a == '0);
  endfunction

  // Port 1 (load) is checked first so it overrides port 0 on a shared address.
  function automatic logic [XLEN-1:0] bypass_read(
    input logic            active,
    input logic [AW-1:0]   rs,
    input logic [XLEN-1:0] stored,
    input logic            b_we0,
    input logic [AW-1:0]   b_wa0,
    input logic [XLEN-1:0] b_wd0,
    input logic            b_we1,
    input logic [AW-1:0]   b_wa1,
    input logic [XLEN-1:0] b_wd1
  );
    if (!active || is_zero_reg(rs)) return '0;
    if (b_we1 && (b_wa1 == rs)) return b_wd1;
    if (b_we0 && (b_wa0 == rs)) return b_wd0;
    return stored;
  endfunction

  assign run    = (state == RUN);
  assign ready  = run;
  assign wr0_ok = run && we0 && !is_zero_reg(wa0);
  assign wr1_ok = run && we1 && !is_zero_reg(wa1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        if (clr_ptr == LAST_REG) begin
          state_nxt   = RUN;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + AW'(1);
        end
      end
      RUN: begin
        if (clear_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Storage carries no reset; the sequencer walks it to zero instead.
  always_ff @(posedge clock) begin
    if (!run) begin
      regs[clr_ptr] <= '0;
    end else begin
      if (wr0_ok) regs[wa0] <= wd0;
      if (wr1_ok) regs[wa1] <= wd1;
    end
  end

  always_comb begin
    rd1 = bypass_read(run, rs1, regs[rs1], we0, wa0, wd0, we1, wa1, wd1);
    rd2 = bypass_read(run, rs2, regs[rs2], we0, wa0, wd0, we1, wa1, wd1);
  end

`ifdef REGFILE_TRACE_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Dump shows the array as it stands once this edge's writes have landed.
  always @(posedge clock) begin
    if (!reset && (wr0_ok || wr1_ok)) begin
      if (wr0_ok) $display("[%0d] port0 x%0d <= %h", cycle_cnt, wa0, wd0);
      if (wr1_ok) $display("[%0d] port1 x%0d <= %h", cycle_cnt, wa1, wd1);
      for (int n = 0; n < NREGS; n++) begin
        if (wr1_ok && (wa1 == AW'(n)))      $display("x%0d=%h", n, wd1);
        else if (wr0_ok && (wa0 == AW'(n))) $display("x%0d=%h", n, wd0);
        else                                $display("x%0d=%h", n, regs[n]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: one ZERO_REG=1 and one ZERO_REG=0 instance
// on shared inputs, compared every cycle against a behavioural register-file model.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            clear_req = 1'b0;
  logic            we0 = 1'b0;
  logic            we1 = 1'b0;
  logic [AW-1:0]   wa0 = '0;
  logic [AW-1:0]   wa1 = '0;
  logic [AW-1:0]   rs1 = '0;
  logic [AW-1:0]   rs2 = '0;
  logic [XLEN-1:0] wd0 = '0;
  logic [XLEN-1:0] wd1 = '0;
  logic            ready_z, ready_n;
  logic [XLEN-1:0] rd1_z, rd2_z, rd1_n, rd2_n;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // mem[0] models the ZERO_REG=1 instance, mem[1] the ZERO_REG=0 instance.
  logic [XLEN-1:0] mem [2][NREGS];
  int clear_left = NREGS;

  always #5 clock = ~clock;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(1'b1)) dut_z (
    .clock(clock), .reset(reset), .clear_req(clear_req), .ready(ready_z),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rs1(rs1), .rs2(rs2), .rd1(rd1_z), .rd2(rd2_z));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .ZERO_REG(1'b0)) dut_n (
    .clock(clock), .reset(reset), .clear_req(clear_req), .ready(ready_n),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rs1(rs1), .rs2(rs2), .rd1(rd1_n), .rd2(rd2_n));

  // Model: the array is usable once NREGS clean edges have passed since reset or a clear request.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      clear_left = NREGS;
    end else if (clear_left > 0) begin
      clear_left = clear_left - 1;
      if (clear_left == 0)
        for (int k = 0; k < 2; k++)
          for (int j = 0; j < NREGS; j++) mem[k][j] = '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we0 && !(k == 0 && wa0 == 0)) mem[k][wa0] = wd0;
        if (we1 && !(k == 0 && wa1 == 0)) mem[k][wa1] = wd1;
      end
      if (clear_req) clear_left = NREGS;
    end
  end

  function automatic logic exp_ready();
    return !reset && (clear_left == 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(int k, logic [AW-1:0] rs);
    if (reset || clear_left > 0) return '0;
    if (k == 0 && rs == 0) return '0;
    if (we1 && wa1 == rs) return wd1;
    if (we0 && wa0 == rs) return wd0;
    return mem[k][rs];
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("ready_z", XLEN'(ready_z), XLEN'(exp_ready()));
      check("ready_n", XLEN'(ready_n), XLEN'(exp_ready()));
      check("rd1_z", rd1_z, exp_rd(0, rs1));
      check("rd2_z", rd2_z, exp_rd(0, rs2));
      check("rd1_n", rd1_n, exp_rd(1, rs1));
      check("rd2_n", rd2_n, exp_rd(1, rs2));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; clear_req = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready_z && n < 100) begin
      step();
      n++;
    end
    check(name, XLEN'(n), XLEN'(NREGS));
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    check("ready_in_reset", XLEN'(ready_z), '0);
    reset = 1'b0;
    chk_en = 1'b1;
    wait_ready("clear_len_after_reset");

    for (int i = 0; i < NREGS; i++) begin
      rs1 = AW'(i); rs2 = AW'(NREGS - 1 - i);
      @(negedge clock);
      check("cleared_rd1", rd1_n, 32'h0);
      check("cleared_rd2", rd2_n, 32'h0);
      step();
    end

    we0 = 1'b1; wa0 = 5; wd0 = 32'hDEADBEEF; rs1 = 5;
    @(negedge clock);
    check("bypass_x5", rd1_z, 32'hDEADBEEF);
    step(); idle();
    @(negedge clock);
    check("stored_x5", rd1_z, 32'hDEADBEEF);
    step();

    we0 = 1'b1; wa0 = 7; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 7; wd1 = 32'h22222222; rs2 = 7;
    @(negedge clock);
    check("conflict_bypass", rd2_z, 32'h22222222);
    step(); idle();
    @(negedge clock);
    check("conflict_stored", rd2_z, 32'h22222222);
    step();

    we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFFFFFF; rs1 = 0;
    @(negedge clock);
    check("x0_bypass_zero", rd1_z, 32'h0);
    check("x0_bypass_plain", rd1_n, 32'hFFFFFFFF);
    step(); idle();
    @(negedge clock);
    check("x0_stored_zero", rd1_z, 32'h0);
    check("x0_stored_plain", rd1_n, 32'hFFFFFFFF);
    step();

    we0 = 1'b1; wa0 = 3; wd0 = 32'hA5A5A5A5;
    step(); idle(); rs1 = 3; rs2 = 9;
    @(negedge clock);
    check("x3_written", rd1_z, 32'hA5A5A5A5);
    clear_req = 1'b1;
    step();
    n = 0;
    while (!ready_z && n < 100) begin
      clear_req = 1'($urandom % 2);
      we0 = 1'b1; wa0 = 9; wd0 = 32'h12345678;
      we1 = 1'($urandom % 2); wa1 = AW'($urandom); wd1 = $urandom;
      @(negedge clock);
      check("rd_during_clear", rd2_n, 32'h0);
      step();
      n++;
    end
    check("clear_len_after_req", XLEN'(n), XLEN'(NREGS));
    idle();
    @(negedge clock);
    check("x3_after_clear", rd1_n, 32'h0);
    check("x9_write_ignored", rd2_n, 32'h0);
    step();

    clear_req = 1'b1;
    step(); idle();
    repeat (10) step();
    #2 reset = 1'b1;
    #1 check("async_reset_ready", XLEN'(ready_z), 32'h0);
    step(); step();
    reset = 1'b0;
    wait_ready("clear_len_after_midreset");

    for (int c = 0; c < 2000; c++) begin
      we0 = 1'($urandom % 2); wa0 = AW'($urandom); wd0 = $urandom;
      we1 = 1'($urandom % 2); wa1 = ($urandom % 4 == 0) ? wa0 : AW'($urandom); wd1 = $urandom;
      rs1 = ($urandom % 3 == 0) ? wa0 : AW'($urandom);
      rs2 = ($urandom % 3 == 0) ? wa1 : AW'($urandom);
      clear_req = ($urandom % 128 == 0);
      step();
    end
    idle();
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
